volume_controller: RTL and testbench

Parametrised volume state machine for the music player. It turns the held `aumenta`/`diminui`/`mute` buttons into a saturating volume level with auto-repeat and a mute/restore function, and drives BCD digits to the `Display` block. It also generates the retriggerable `display_select` hold, which replaces the fixed-behaviour volume FSM and the display select counter with one configurable block.

---
 rtl/player_pkg.sv | 15 +
 rtl/button_repeat.sv | 47 ++++
 rtl/volume_controller.sv | 117 +++++++++++
 tb/tb_volume_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared constants and helpers for the player display paths (volume and timer).
// bin2bcd splits a 0..99 binary value into tens/units BCD digits.
package player_pkg;

  localparam int BCD_W = 4;

  function automatic logic [2*BCD_W-1:0] bin2bcd(input logic [6:0] bin);
    logic [6:0] tens;
    logic [6:0] units;
    tens  = bin / 7'd10;
    units = bin % 7'd10;
    return {tens[BCD_W-1:0], units[BCD_W-1:0]};
  endfunction

endpackage

// File: rtl/button_repeat.sv
// Press-edge detector with hold auto-repeat; o_step fires combinationally on the press edge,
// then REPEAT_DELAY edges later and every REPEAT_RATE edges while held. No backpressure.
module button_repeat #(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 5
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  input  logic i_clear,
  output logic o_press,
  output logic o_step
);

  localparam int MAXC = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(MAXC + 1);

  logic          r_btn_q;
  logic [CW-1:0] r_cnt;
  logic          w_press;
  logic          w_fire;

  assign w_press = i_btn & ~r_btn_q;
  // A zero counter while held means repeats are disarmed until a fresh press.
  assign w_fire  = i_btn & r_btn_q & (r_cnt == CW'(1));
  assign o_press = w_press & ~i_clear;
  assign o_step  = (w_press | w_fire) & ~i_clear;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_btn_q <= i_btn;
      r_cnt   <= '0;
    end else begin
      r_btn_q <= i_btn;
      if (i_clear || !i_btn) begin
        r_cnt <= '0;
      end else if (w_press) begin
        r_cnt <= CW'(REPEAT_DELAY);
      end else if (w_fire) begin
        r_cnt <= CW'(REPEAT_RATE);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/volume_controller.sv
// Saturating volume level with auto-repeat, mute/restore, change pulse and display hold.
// Level and pulse update one edge after a press; display_select one edge later. No backpressure.
module volume_controller
  import player_pkg::*;
#(
  parameter int MAX_LEVEL     = 15,
  parameter int STEP          = 1,
  parameter int DEFAULT_LEVEL = 8,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_RATE   = 5,
  parameter int HOLD_CYCLES   = 50
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             aumenta,
  input  logic                             diminui,
  input  logic                             mute,
  output logic [$clog2(MAX_LEVEL+1)-1:0]   level,
  output logic                             muted,
  output logic [BCD_W-1:0]                 volume1,
  output logic [BCD_W-1:0]                 volume0,
  output logic                             mudou_volume,
  output logic                             display_select
);

  localparam int          LW     = $clog2(MAX_LEVEL + 1);
  localparam int          HW     = $clog2(HOLD_CYCLES + 1);
  localparam logic [LW:0] MAX_W  = (LW+1)'(MAX_LEVEL);
  localparam logic [LW:0] STEP_W = (LW+1)'(STEP);

  logic              w_both;
  logic              w_up_press;
  logic              w_up_step;
  logic              w_dn_press;
  logic              w_dn_step;
  logic              w_mute_press;
  logic              r_mute_q;
  logic [LW-1:0]     r_saved;
  logic [LW-1:0]     r_level;
  logic              r_muted;
  logic              r_mudou;
  logic [HW-1:0]     r_hold;
  logic              r_disp;
  logic [LW-1:0]     w_saved_n;
  logic [LW-1:0]     w_level_n;
  logic              w_muted_n;
  logic [LW:0]       w_sum;
  logic [LW:0]       w_diff;
  logic [2*BCD_W-1:0] w_bcd;

  assign w_both       = aumenta & diminui;
  assign w_mute_press = mute & ~r_mute_q;

  button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .i_clk(clk), .i_reset(reset), .i_btn(aumenta), .i_clear(w_both),
    .o_press(w_up_press), .o_step(w_up_step)
  );

  button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dn (
    .i_clk(clk), .i_reset(reset), .i_btn(diminui), .i_clear(w_both),
    .o_press(w_dn_press), .o_step(w_dn_step)
  );

  always_comb begin
    w_saved_n = r_saved;
    w_muted_n = r_muted;
    w_sum     = {1'b0, r_saved} + STEP_W;
    w_diff    = ({1'b0, r_saved} >= STEP_W) ? ({1'b0, r_saved} - STEP_W) : '0;
    // Mute edge wins; while muted, an up/down edge only restores, and held repeats are ignored.
    if (w_mute_press) begin
      w_muted_n = ~r_muted;
    end else if (r_muted) begin
      if (w_up_press || w_dn_press) w_muted_n = 1'b0;
    end else if (w_up_step) begin
      w_saved_n = (w_sum > MAX_W) ? MAX_W[LW-1:0] : w_sum[LW-1:0];
    end else if (w_dn_step) begin
      w_saved_n = w_diff[LW-1:0];
    end
    w_level_n = w_muted_n ? '0 : w_saved_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mute_q <= mute;
      r_saved  <= LW'(DEFAULT_LEVEL);
      r_level  <= LW'(DEFAULT_LEVEL);
      r_muted  <= 1'b0;
      r_mudou  <= 1'b0;
      r_hold   <= '0;
      r_disp   <= 1'b0;
    end else begin
      r_mute_q <= mute;
      r_saved  <= w_saved_n;
      r_level  <= w_level_n;
      r_muted  <= w_muted_n;
      r_mudou  <= (w_level_n != r_level) || (w_muted_n != r_muted);
      if (r_mudou) begin
        r_hold <= HW'(HOLD_CYCLES);
        r_disp <= 1'b1;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - HW'(1);
        r_disp <= (r_hold != HW'(1));
      end else begin
        r_disp <= 1'b0;
      end
    end
  end

  assign w_bcd          = bin2bcd(7'(r_level));
  assign level          = r_level;
  assign muted          = r_muted;
  assign mudou_volume   = r_mudou;
  assign display_select = r_disp;
  assign volume1        = w_bcd[2*BCD_W-1:BCD_W];
  assign volume0        = w_bcd[BCD_W-1:0];

endmodule

// File: tb/tb_volume_controller.sv
// Directed bench for volume_controller at default parameters.
module tb_volume_controller;

  logic       clk;
  logic       reset;
  logic       aumenta;
  logic       diminui;
  logic       mute;
  logic [3:0] level;
  logic       muted;
  logic [3:0] volume1;
  logic [3:0] volume0;
  logic       mudou_volume;
  logic       display_select;

  int n_pass;
  int n_total;
  int pulse_cnt;
  int disp_cnt;

  volume_controller #(
    .MAX_LEVEL(15), .STEP(1), .DEFAULT_LEVEL(8),
    .REPEAT_DELAY(20), .REPEAT_RATE(5), .HOLD_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .aumenta(aumenta), .diminui(diminui), .mute(mute),
    .level(level), .muted(muted), .volume1(volume1), .volume0(volume0),
    .mudou_volume(mudou_volume), .display_select(display_select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pulse_cnt = 0;
  initial disp_cnt  = 0;
  always @(negedge clk) begin
    if (mudou_volume === 1'b1) pulse_cnt = pulse_cnt + 1;
    if (display_select === 1'b1) disp_cnt = disp_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int p0;
    reset = 1'b1; aumenta = 1'b0; diminui = 1'b0; mute = 1'b0;
    tick(2);
    reset = 1'b0;
    p0 = pulse_cnt;
    tick(100);
    n_total++; if (level !== 4'd8) $display("FAIL reset_level got %0d exp 8", level); else n_pass++;
    n_total++; if (volume1 !== 4'd0 || volume0 !== 4'd8)
      $display("FAIL reset_digits got %0d/%0d exp 0/8", volume1, volume0); else n_pass++;
    n_total++; if (pulse_cnt - p0 !== 0) $display("FAIL reset_pulses got %0d exp 0", pulse_cnt - p0); else n_pass++;
    n_total++; if (display_select !== 1'b0 || muted !== 1'b0)
      $display("FAIL reset_disp_mute got %b%b exp 00", display_select, muted); else n_pass++;
  endtask

  task automatic test_single_press();
    int p0, d0;
    p0 = pulse_cnt; d0 = disp_cnt;
    aumenta = 1'b1;
    tick(1);
    aumenta = 1'b0;
    n_total++; if (level !== 4'd9 || mudou_volume !== 1'b1)
      $display("FAIL single_step got lvl=%0d pulse=%b exp 9/1", level, mudou_volume); else n_pass++;
    n_total++; if (display_select !== 1'b0) $display("FAIL single_disp_early got %b exp 0", display_select); else n_pass++;
    tick(1);
    n_total++; if (display_select !== 1'b1 || mudou_volume !== 1'b0)
      $display("FAIL single_disp_rise got disp=%b pulse=%b exp 1/0", display_select, mudou_volume); else n_pass++;
    tick(60);
    n_total++; if (pulse_cnt - p0 !== 1) $display("FAIL single_pulses got %0d exp 1", pulse_cnt - p0); else n_pass++;
    n_total++; if (disp_cnt - d0 !== 50) $display("FAIL single_hold_len got %0d exp 50", disp_cnt - d0); else n_pass++;
    n_total++; if (display_select !== 1'b0) $display("FAIL single_disp_fall got %b exp 0", display_select); else n_pass++;
  endtask

  task automatic test_auto_repeat();
    int p0;
    diminui = 1'b1; tick(1); diminui = 1'b0;
    tick(60);
    n_total++; if (level !== 4'd8) $display("FAIL repeat_start got %0d exp 8", level); else n_pass++;
    p0 = pulse_cnt;
    aumenta = 1'b1;
    tick(1);
    n_total++; if (level !== 4'd9) $display("FAIL repeat_first got %0d exp 9", level); else n_pass++;
    tick(19);
    n_total++; if (level !== 4'd9) $display("FAIL repeat_before_delay got %0d exp 9", level); else n_pass++;
    tick(1);
    n_total++; if (level !== 4'd10) $display("FAIL repeat_at_delay got %0d exp 10", level); else n_pass++;
    tick(5);
    n_total++; if (level !== 4'd11) $display("FAIL repeat_rate got %0d exp 11", level); else n_pass++;
    tick(34);
    aumenta = 1'b0;
    tick(5);
    n_total++; if (level !== 4'd15) $display("FAIL repeat_sat got %0d exp 15", level); else n_pass++;
    n_total++; if (pulse_cnt - p0 !== 7) $display("FAIL repeat_pulses got %0d exp 7", pulse_cnt - p0); else n_pass++;
    n_total++; if (volume1 !== 4'd1 || volume0 !== 4'd5)
      $display("FAIL repeat_digits got %0d/%0d exp 1/5", volume1, volume0); else n_pass++;
  endtask

  task automatic test_mute();
    int p0;
    for (int i = 0; i < 3; i++) begin
      diminui = 1'b1; tick(1); diminui = 1'b0; tick(1);
    end
    n_total++; if (level !== 4'd12) $display("FAIL mute_setup got %0d exp 12", level); else n_pass++;
    tick(10);
    p0 = pulse_cnt;
    mute = 1'b1; tick(1); mute = 1'b0;
    n_total++; if (muted !== 1'b1 || level !== 4'd0 || mudou_volume !== 1'b1)
      $display("FAIL mute_on got m=%b lvl=%0d pulse=%b exp 1/0/1", muted, level, mudou_volume); else n_pass++;
    n_total++; if (volume1 !== 4'd0 || volume0 !== 4'd0)
      $display("FAIL mute_digits got %0d/%0d exp 0/0", volume1, volume0); else n_pass++;
    tick(3);
    diminui = 1'b1; tick(1); diminui = 1'b0;
    n_total++; if (muted !== 1'b0 || level !== 4'd12 || mudou_volume !== 1'b1)
      $display("FAIL mute_restore got m=%b lvl=%0d pulse=%b exp 0/12/1", muted, level, mudou_volume); else n_pass++;
    tick(3);
    n_total++; if (pulse_cnt - p0 !== 2) $display("FAIL mute_pulses got %0d exp 2", pulse_cnt - p0); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int p0;
    tick(10);
    p0 = pulse_cnt;
    aumenta = 1'b1; diminui = 1'b1;
    tick(30);
    aumenta = 1'b0; diminui = 1'b0;
    tick(2);
    n_total++; if (level !== 4'd12 || pulse_cnt - p0 !== 0)
      $display("FAIL both_no_step got lvl=%0d pulses=%0d exp 12/0", level, pulse_cnt - p0); else n_pass++;
    tick(1);
    diminui = 1'b1; tick(1); diminui = 1'b0;
    n_total++; if (level !== 4'd11) $display("FAIL both_resume got %0d exp 11", level); else n_pass++;
    tick(3);
    n_total++; if (pulse_cnt - p0 !== 1) $display("FAIL both_pulses got %0d exp 1", pulse_cnt - p0); else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    int p0;
    aumenta = 1'b1;
    tick(40);
    n_total++; if (level !== 4'd15 || display_select !== 1'b1)
      $display("FAIL rst_pre got lvl=%0d disp=%b exp 15/1", level, display_select); else n_pass++;
    reset = 1'b1; tick(1); reset = 1'b0;
    n_total++; if (level !== 4'd8 || display_select !== 1'b0 || mudou_volume !== 1'b0 || muted !== 1'b0)
      $display("FAIL rst_state got lvl=%0d disp=%b pulse=%b m=%b exp 8/0/0/0",
               level, display_select, mudou_volume, muted); else n_pass++;
    p0 = pulse_cnt;
    tick(30);
    n_total++; if (level !== 4'd8 || pulse_cnt - p0 !== 0)
      $display("FAIL rst_held got lvl=%0d pulses=%0d exp 8/0", level, pulse_cnt - p0); else n_pass++;
    aumenta = 1'b0; tick(2);
    aumenta = 1'b1; tick(1); aumenta = 1'b0;
    n_total++; if (level !== 4'd9) $display("FAIL rst_repress got %0d exp 9", level); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; aumenta = 1'b0; diminui = 1'b0; mute = 1'b0;
    test_reset();
    test_single_press();
    test_auto_repeat();
    test_mute();
    test_simultaneous();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
